eth_udp_parser: RTL and testbench
=================================

# eth_udp_parser

Strips Ethernet II, IPv4 and UDP headers from a received frame byte stream and forwards only the UDP payload of frames addressed to a configured destination port. It sits directly downstream of the RGMII receive stage, which supplies preamble/SFD-stripped frame bytes. Its payload output feeds the market-data/book logic. Malformed, filtered and errored frames are discarded and counted.

## Interface
- DST_PORT, 16'd12345, UDP destination port accepted; all others are dropped.
- CHECK_MAC, 1'b0, when 1, the destination MAC must equal LOCAL_MAC or ff:ff:ff:ff:ff:ff.
- LOCAL_MAC, 48'h02_00_00_00_00_01, station MAC used when CHECK_MAC=1.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data  in  8  frame byte, first byte = destination MAC[47:40].
- dataValid  in  1  byte strobe; a frame is one contiguous run of dataValid=1; a low cycle ends the frame.
- dataErr  in  1  frame error (FCS/PHY); valid only with dataValid=1.
- outData  out  8  UDP payload byte.
- outDataValid  out  1  outData strobe.
- outDataLast  out  1  high with the final payload byte of a frame.
- frameErr  out  1  one-cycle pulse: a frame with payload already forwarded was errored or truncated.
- dropCount  out  16  saturating count of discarded frames.

## Operation
- Byte offsets (0-based): 12-13 EtherType, 14 version/IHL, 23 protocol, 36-37 UDP dst port, 38-39 UDP length, 42+ payload.
- Accept criteria: EtherType=16'h0800; byte 14=8'h45 (no IP options); protocol=8'h11; dst port=DST_PORT; UDP length ≥ 8; MAC check if enabled. All decided by byte 41, so no buffering is needed.
- Payload length L = UDP length − 8; 16-bit compare; L=0 is valid and yields no output.
- States:
  - IDLE: wait for dataValid; first byte counts as header byte 0 → HEADER.
  - HEADER: 6-bit byte counter 0..41. Failed check → DROP. Counter reaching 41 with checks passed → PAYLOAD if L>0, else DRAIN.
  - PAYLOAD: forward each byte, decrementing a 16-bit remaining counter. Last byte asserts outDataLast → DRAIN.
  - DRAIN: discard trailing bytes (Ethernet padding, FCS) until dataValid=0 → IDLE.
  - DROP: discard until dataValid=0 → IDLE.
- dataErr=1 handling:
  - In HEADER → DROP.
  - In PAYLOAD → suppress that byte, pulse frameErr → DROP.
  - In DRAIN → pulse frameErr. The payload is already complete, but the frame failed FCS.
- dataValid=0 before completion:
  - In HEADER → IDLE, counted as a drop.
  - In PAYLOAD → IDLE, pulse frameErr, counted as a drop. outDataLast is never asserted for that frame.
- Each transition into DROP increments dropCount by 1. Truncations and frameErr cases each count exactly once per frame. The counter saturates at 16'hFFFF.
- Back-to-back frames: a single idle cycle between frames is sufficient. IDLE accepts a new byte 0 on the cycle after dataValid falls.

## Timing
- Reset: state=IDLE, counters=0, outData=8'h00, outDataValid=0, outDataLast=0, frameErr=0, dropCount=0.
- Assertion of rst mid-frame aborts the frame immediately. After release the block waits in IDLE; the remainder of the interrupted frame is treated as a new frame, which fails the checks and is dropped.
- Latency: all outputs are registered. Input payload byte at edge t appears on outData/outDataValid after edge t+1.
- frameErr fires one cycle after the offending input cycle, or one cycle after the dataValid-low cycle in the truncation case.
- outDataValid has no backpressure; the consumer must accept one byte per cycle.
- outData holds its last value when outDataValid=0.

## Test plan
- Valid frame, port 12345, UDP length 16 → exactly 8 payload bytes out, 1-cycle latency, outDataLast on byte 8, dropCount=0.
- Frame with dst port 12346, then EtherType 0x86DD, then protocol 0x06 → no output, dropCount=3.
- Minimum 60-byte frame with UDP length 10 plus padding and 4-byte FCS → 2 payload bytes, padding/FCS suppressed, returns to IDLE.
- dataErr on payload byte 3 of 8 → bytes 1-2 out, no outDataLast, frameErr pulse, dropCount=1.
- dataValid drops at header byte 20 → no output, no frameErr, dropCount=1. The next valid frame after a 1-cycle gap is forwarded intact.
- CHECK_MAC=1: frames to LOCAL_MAC and broadcast forwarded, a frame to 02:00:00:00:00:02 dropped. Separately, rst pulsed mid-payload → all outputs 0 and state IDLE.

Source files
------------

// File: rtl/eth_udp_parser.sv
// Ethernet II / IPv4 / UDP receive parser: strips headers on the fly and forwards
// the UDP payload of frames addressed to DST_PORT; discarded frames are counted.
`timescale 1ns/1ps
module eth_udp_parser #(
    parameter logic [15:0] DST_PORT  = 16'd12345,
    parameter logic        CHECK_MAC = 1'b0,
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        dataValid,
    input  logic        dataErr,
    output logic [7:0]  outData,
    output logic        outDataValid,
    output logic        outDataLast,
    output logic        frameErr,
    output logic [15:0] dropCount
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DRAIN,
        DROP
    } state_t;

    state_t      state_q;
    logic [5:0]  byte_cnt_q;
    logic [15:0] remain_q;
    logic [7:0]  len_hi_q;
    logic        mac_local_q;
    logic        mac_bcast_q;
    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic        frame_err_q;
    logic [15:0] drop_cnt_q;

    logic [5:0]  hdr_idx;
    logic [7:0]  mac_exp;
    logic        local_hit;
    logic        bcast_hit;
    logic [15:0] udp_len;
    logic        hdr_fail;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        hdr_idx = (state_q == HEADER) ? byte_cnt_q : 6'd0;
        case (hdr_idx)
            6'd0:    mac_exp = LOCAL_MAC[47:40];
            6'd1:    mac_exp = LOCAL_MAC[39:32];
            6'd2:    mac_exp = LOCAL_MAC[31:24];
            6'd3:    mac_exp = LOCAL_MAC[23:16];
            6'd4:    mac_exp = LOCAL_MAC[15:8];
            6'd5:    mac_exp = LOCAL_MAC[7:0];
            default: mac_exp = 8'h00;
        endcase
        // IDLE presents header byte 0, so the running MAC matches start out true.
        local_hit = ((state_q == HEADER) ? mac_local_q : 1'b1) && (data == mac_exp);
        bcast_hit = ((state_q == HEADER) ? mac_bcast_q : 1'b1) && (data == 8'hFF);
        udp_len   = {len_hi_q, data};
        hdr_fail  = dataErr;
        case (hdr_idx)
            6'd5:    hdr_fail = dataErr || (CHECK_MAC && !(local_hit || bcast_hit));
            6'd12:   hdr_fail = dataErr || (data != 8'h08);
            6'd13:   hdr_fail = dataErr || (data != 8'h00);
            6'd14:   hdr_fail = dataErr || (data != 8'h45);
            6'd23:   hdr_fail = dataErr || (data != 8'h11);
            6'd36:   hdr_fail = dataErr || (data != DST_PORT[15:8]);
            6'd37:   hdr_fail = dataErr || (data != DST_PORT[7:0]);
            6'd39:   hdr_fail = dataErr || (udp_len < 16'd8);
            default: hdr_fail = dataErr;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 6'd0;
            remain_q    <= 16'd0;
            len_hi_q    <= 8'h00;
            mac_local_q <= 1'b0;
            mac_bcast_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
            drop_cnt_q  <= 16'd0;
        end else begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE, HEADER: begin
                    if (!dataValid) begin
                        if (state_q == HEADER) begin
                            state_q    <= IDLE;
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                        end
                    end else begin
                        byte_cnt_q <= hdr_idx + 6'd1;
                        if (hdr_idx < 6'd6) begin
                            mac_local_q <= local_hit;
                            mac_bcast_q <= bcast_hit;
                        end
                        if (hdr_idx == 6'd38) len_hi_q <= data;
                        if (hdr_idx == 6'd39) remain_q <= udp_len - 16'd8;
                        if (hdr_fail) begin
                            state_q    <= DROP;
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                        end else if (hdr_idx == 6'd41) begin
                            state_q <= (remain_q == 16'd0) ? DRAIN : PAYLOAD;
                        end else begin
                            state_q <= HEADER;
                        end
                    end
                end
                PAYLOAD: begin
                    if (!dataValid || dataErr) begin
                        state_q     <= dataValid ? DROP : IDLE;
                        frame_err_q <= 1'b1;
                        drop_cnt_q  <= sat_inc(drop_cnt_q);
                    end else begin
                        out_data_q  <= data;
                        out_valid_q <= 1'b1;
                        remain_q    <= remain_q - 16'd1;
                        if (remain_q == 16'd1) begin
                            out_last_q <= 1'b1;
                            state_q    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // An FCS error after a complete payload still flags the frame once.
                    if (!dataValid) begin
                        state_q <= IDLE;
                    end else if (dataErr) begin
                        state_q     <= DROP;
                        frame_err_q <= 1'b1;
                        drop_cnt_q  <= sat_inc(drop_cnt_q);
                    end
                end
                DROP: begin
                    if (!dataValid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign outData      = out_data_q;
    assign outDataValid = out_valid_q;
    assign outDataLast  = out_last_q;
    assign frameErr     = frame_err_q;
    assign dropCount    = drop_cnt_q;

endmodule

// File: tb/tb_eth_udp_parser.sv
// Directed bench for eth_udp_parser: builds frames byte by byte, drives them and
// compares forwarded payload, flags and drop counts against hand-derived values.
`timescale 1ns/1ps
module tb_eth_udp_parser;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        data_valid;
    logic        data_err;

    logic [7:0]  out_data,  mac_out_data;
    logic        out_valid, mac_out_valid;
    logic        out_last,  mac_out_last;
    logic        frame_err, mac_frame_err;
    logic [15:0] drop_count, mac_drop_count;

    always #5 clk = ~clk;

    eth_udp_parser #(.CHECK_MAC(1'b0)) dut (
        .clk(clk), .rst(rst), .data(data), .dataValid(data_valid), .dataErr(data_err),
        .outData(out_data), .outDataValid(out_valid), .outDataLast(out_last),
        .frameErr(frame_err), .dropCount(drop_count)
    );

    eth_udp_parser #(.CHECK_MAC(1'b1)) dut_mac (
        .clk(clk), .rst(rst), .data(data), .dataValid(data_valid), .dataErr(data_err),
        .outData(mac_out_data), .outDataValid(mac_out_valid), .outDataLast(mac_out_last),
        .frameErr(mac_frame_err), .dropCount(mac_drop_count)
    );

    // Output collectors, sampled on the falling edge away from the active edge.
    int         cyc = 0;
    logic [7:0] out_q[$];
    int         out_cyc_q[$];
    int         last_cnt = 0, last_pos = 0, ferr_cnt = 0;
    logic [7:0] mac_q[$];
    int         mac_last_cnt = 0, mac_ferr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            out_q.push_back(out_data);
            out_cyc_q.push_back(cyc);
            if (out_last) begin
                last_cnt <= last_cnt + 1;
                last_pos <= out_q.size();
            end
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (mac_out_valid) begin
            mac_q.push_back(mac_out_data);
            if (mac_out_last) mac_last_cnt <= mac_last_cnt + 1;
        end
        if (mac_frame_err) mac_ferr_cnt <= mac_ferr_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] frame[$];
    int         pay_cyc;

    task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                               input logic [7:0] ver, input logic [7:0] proto,
                               input logic [15:0] dport, input logic [15:0] ulen,
                               input int npay, input int npad, input logic [7:0] pbase);
        logic [15:0] tot_len;
        tot_len = ulen + 16'd20;
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(dmac[8*(5-i) +: 8]);
        frame.push_back(8'h02); frame.push_back(8'h00); frame.push_back(8'h00);
        frame.push_back(8'h00); frame.push_back(8'h00); frame.push_back(8'h09);
        frame.push_back(etype[15:8]); frame.push_back(etype[7:0]);
        frame.push_back(ver); frame.push_back(8'h00);
        frame.push_back(tot_len[15:8]); frame.push_back(tot_len[7:0]);
        frame.push_back(8'h12); frame.push_back(8'h34);
        frame.push_back(8'h40); frame.push_back(8'h00);
        frame.push_back(8'h40); frame.push_back(proto);
        frame.push_back(8'h00); frame.push_back(8'h00);
        frame.push_back(8'hC0); frame.push_back(8'hA8); frame.push_back(8'h00); frame.push_back(8'h01);
        frame.push_back(8'hE0); frame.push_back(8'h00); frame.push_back(8'h00); frame.push_back(8'h01);
        frame.push_back(8'h1F); frame.push_back(8'h90);
        frame.push_back(dport[15:8]); frame.push_back(dport[7:0]);
        frame.push_back(ulen[15:8]); frame.push_back(ulen[7:0]);
        frame.push_back(8'h00); frame.push_back(8'h00);
        for (int i = 0; i < npay; i++) frame.push_back(8'(pbase + 8'(i)));
        for (int i = 0; i < npad; i++) frame.push_back(8'h00);
        frame.push_back(8'hDE); frame.push_back(8'hAD); frame.push_back(8'hBE); frame.push_back(8'hEF);
    endtask

    // Drives the built frame; optional error byte, truncation point and mid-frame reset.
    task automatic send(input int err_idx, input int trunc_idx, input int rst_idx, input int gap);
        for (int i = 0; i < frame.size(); i++) begin
            if (i == trunc_idx) break;
            data       = frame[i];
            data_valid = 1'b1;
            data_err   = (i == err_idx);
            if (i == 42) pay_cyc = cyc;
            if (rst_idx >= 0 && i == rst_idx + 1) rst = 1'b0;
            if (i == rst_idx) begin
                #2 rst = 1'b1;
                #1;
                check("rst_out_data", {24'd0, out_data}, 32'h0);
                check("rst_out_valid", {31'd0, out_valid}, 32'h0);
                check("rst_out_last", {31'd0, out_last}, 32'h0);
                check("rst_frame_err", {31'd0, frame_err}, 32'h0);
                check("rst_drop_count", {16'd0, drop_count}, 32'h0);
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        data_err   = 1'b0;
        data       = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_bytes(input string tag, input bit use_mac, input int base,
                               input int n, input logic [7:0] pbase);
        int         sz;
        logic [7:0] obs;
        logic [7:0] exp_b;
        sz = use_mac ? mac_q.size() : out_q.size();
        for (int i = 0; i < n; i++) begin
            if (base + i < sz) obs = use_mac ? mac_q[base+i] : out_q[base+i];
            else obs = 8'hxx;
            exp_b = 8'(pbase + 8'(i));
            check($sformatf("%s_byte%0d", tag, i), {24'd0, obs}, {24'd0, exp_b});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

    initial begin
        int base, mbase, lb, mlb, fb;
        rst        = 1'b1;
        data       = 8'h00;
        data_valid = 1'b0;
        data_err   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_data", {24'd0, out_data}, 32'h0);
        check("reset_out_valid", {31'd0, out_valid}, 32'h0);
        check("reset_out_last", {31'd0, out_last}, 32'h0);
        check("reset_frame_err", {31'd0, frame_err}, 32'h0);
        check("reset_drop_count", {16'd0, drop_count}, 32'h0);
        check("reset_mac_drop_count", {16'd0, mac_drop_count}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Valid frame, UDP length 16 -> 8 payload bytes.
        base = out_q.size(); lb = last_cnt; fb = ferr_cnt;
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd16, 8, 0, 8'hA0);
        send(-1, -1, -1, 2);
        check("t1_count", 32'(out_q.size() - base), 32'd8);
        check_bytes("t1", 1'b0, base, 8, 8'hA0);
        check("t1_last_cnt", 32'(last_cnt - lb), 32'd1);
        check("t1_last_pos", 32'(last_pos), 32'(base + 8));
        check("t1_latency", 32'((out_q.size() > base) ? out_cyc_q[base] : -1), 32'(pay_cyc + 1));
        check("t1_frame_err", 32'(ferr_cnt - fb), 32'd0);
        check("t1_drop", {16'd0, drop_count}, 32'd0);

        // Filtered frames: wrong port, IPv6 EtherType, TCP protocol.
        base = out_q.size();
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 16'd12346, 16'd16, 8, 0, 8'hB0);
        send(-1, -1, -1, 1);
        build_frame(LOCAL_MAC, 16'h86DD, 8'h45, 8'h11, 16'd12345, 16'd16, 8, 0, 8'hB0);
        send(-1, -1, -1, 1);
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h06, 16'd12345, 16'd16, 8, 0, 8'hB0);
        send(-1, -1, -1, 2);
        check("t2_count", 32'(out_q.size() - base), 32'd0);
        check("t2_drop", {16'd0, drop_count}, 32'd3);

        // Minimum-size frame: UDP length 10, 16 pad bytes, FCS.
        base = out_q.size(); lb = last_cnt;
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd10, 2, 16, 8'hC0);
        check("t3_frame_len", 32'(frame.size()), 32'd64);
        send(-1, -1, -1, 1);
        check("t3_count", 32'(out_q.size() - base), 32'd2);
        check_bytes("t3", 1'b0, base, 2, 8'hC0);
        check("t3_last_cnt", 32'(last_cnt - lb), 32'd1);
        check("t3_drop", {16'd0, drop_count}, 32'd3);

        // Same frame with a bad FCS byte: payload out, then frameErr and one drop.
        base = out_q.size(); fb = ferr_cnt;
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd10, 2, 16, 8'hC8);
        send(63, -1, -1, 2);
        check("t3b_count", 32'(out_q.size() - base), 32'd2);
        check("t3b_frame_err", 32'(ferr_cnt - fb), 32'd1);
        check("t3b_drop", {16'd0, drop_count}, 32'd4);

        // dataErr on payload byte 3 of 8.
        base = out_q.size(); lb = last_cnt; fb = ferr_cnt;
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd16, 8, 0, 8'hD0);
        send(44, -1, -1, 2);
        check("t4_count", 32'(out_q.size() - base), 32'd2);
        check_bytes("t4", 1'b0, base, 2, 8'hD0);
        check("t4_last_cnt", 32'(last_cnt - lb), 32'd0);
        check("t4_frame_err", 32'(ferr_cnt - fb), 32'd1);
        check("t4_drop", {16'd0, drop_count}, 32'd5);

        // Truncation at header byte 20, then a good frame after one idle cycle.
        base = out_q.size(); lb = last_cnt; fb = ferr_cnt;
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd16, 8, 0, 8'hE0);
        send(-1, 20, -1, 1);
        check("t5_trunc_count", 32'(out_q.size() - base), 32'd0);
        check("t5_trunc_frame_err", 32'(ferr_cnt - fb), 32'd0);
        check("t5_trunc_drop", {16'd0, drop_count}, 32'd6);
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd16, 8, 0, 8'h50);
        send(-1, -1, -1, 2);
        check("t5_next_count", 32'(out_q.size() - base), 32'd8);
        check_bytes("t5_next", 1'b0, base, 8, 8'h50);
        check("t5_next_last_cnt", 32'(last_cnt - lb), 32'd1);
        check("t5_next_drop", {16'd0, drop_count}, 32'd6);

        // UDP length 8 (empty payload) is accepted silently; length 7 is malformed.
        base = out_q.size(); lb = last_cnt;
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd8, 0, 18, 8'h00);
        send(-1, -1, -1, 1);
        check("t6_len8_count", 32'(out_q.size() - base), 32'd0);
        check("t6_len8_last", 32'(last_cnt - lb), 32'd0);
        check("t6_len8_drop", {16'd0, drop_count}, 32'd6);
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd7, 0, 18, 8'h00);
        send(-1, -1, -1, 2);
        check("t6_len7_drop", {16'd0, drop_count}, 32'd7);

        // Reset during payload byte 4; the tail arrives as a new, failing frame.
        base = out_q.size();
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd16, 8, 0, 8'hA0);
        send(-1, -1, 45, 2);
        check("t7_count", 32'(out_q.size() - base), 32'd3);
        check("t7_tail_drop", {16'd0, drop_count}, 32'd1);
        check("t7_mac_tail_drop", {16'd0, mac_drop_count}, 32'd1);

        // Destination MAC filter: local and broadcast pass, another station is dropped.
        base = out_q.size(); mbase = mac_q.size(); mlb = mac_last_cnt;
        build_frame(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd12, 4, 14, 8'h10);
        send(-1, -1, -1, 1);
        build_frame(BCAST_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd12, 4, 14, 8'h20);
        send(-1, -1, -1, 1);
        build_frame(OTHER_MAC, 16'h0800, 8'h45, 8'h11, 16'd12345, 16'd12, 4, 14, 8'h30);
        send(-1, -1, -1, 2);
        check("t8_main_count", 32'(out_q.size() - base), 32'd12);
        check("t8_main_drop", {16'd0, drop_count}, 32'd1);
        check("t8_mac_count", 32'(mac_q.size() - mbase), 32'd8);
        check_bytes("t8_mac_local", 1'b1, mbase, 4, 8'h10);
        check_bytes("t8_mac_bcast", 1'b1, mbase + 4, 4, 8'h20);
        check("t8_mac_last_cnt", 32'(mac_last_cnt - mlb), 32'd2);
        check("t8_mac_drop", {16'd0, mac_drop_count}, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
